// File: rtl/uart_pkg.sv
// Shared UART constants: receive FIFO defaults and status-word bit positions
// used by the register file when it packs the status register.
package uart_pkg;

  localparam int RX_FIFO_DEPTH     = 16;
  localparam int RX_TIMEOUT_CYCLES = 8333;

  localparam int STAT_EMPTY_IDX   = 0;
  localparam int STAT_FULL_IDX    = 1;
  localparam int STAT_OVERRUN_IDX = 2;
  localparam int STAT_BREAK_IDX   = 3;
  localparam int STAT_TIMEOUT_IDX = 4;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Receive FIFO storage: DEPTH x 8 register array, synchronous write and
// combinational (show-ahead) read. Pointer and flag logic lives in the parent.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] mem_q [DEPTH];

  // NOTE: storage has no reset; emptiness is tracked by the pointers, so
  // resetting the array would only add a reset net to every data flop.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the serial receiver and the register file, with
// sticky overrun/break flags. Optional idle timeout: define UART_RX_TIMEOUT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH          = RX_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = RX_TIMEOUT_CYCLES
) (
  input  logic                     i_wb_clk,
  input  logic                     wb_rst,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  input  logic                     i_rx_break,
  input  logic                     i_pop,
  input  logic                     i_clr_status,
  output logic [7:0]               o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overrun,
  output logic                     o_break,
  output logic                     o_timeout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overrun_q, overrun_d;
  logic        break_q, break_d;
  logic        empty, full;
  logic        push_ok, pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_ok  = i_pop && !empty;
  assign push_ok = i_rx_valid && (!full || pop_ok);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q && !i_clr_status;
    break_d   = break_q && !i_clr_status;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (i_rx_valid && !push_ok) overrun_d = 1'b1;
    if (i_rx_break) break_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge i_wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
      break_q   <= break_d;
    end
  end

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (i_wb_clk),
    .i_we    (push_ok),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wdata (i_rx_data),
    .i_raddr (rd_ptr_q[AW-1:0]),
    .o_rdata (o_data)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          timeout_q, timeout_d;
  logic          idle_hit;

  assign idle_hit = !push_ok && !pop_ok && !empty && (idle_cnt_q == CNT_LAST);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    timeout_d  = timeout_q;
    if (push_ok || pop_ok || empty) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != CNT_LAST) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
    if (pop_ok || (wr_ptr_d == rd_ptr_d) || i_clr_status) timeout_d = 1'b0;
    if (idle_hit) timeout_d = 1'b1;
  end

  always_ff @(posedge i_wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  // Timeout disabled in this build; the parameter is kept so callers need no change.
  if (TIMEOUT_CYCLES > 0) begin : g_no_timeout
    assign o_timeout = 1'b0;
  end else begin : g_no_timeout_alt
    assign o_timeout = 1'b0;
  end
`endif

  assign o_empty   = empty;
  assign o_full    = full;
  assign o_level   = wr_ptr_q - rd_ptr_q;
  assign o_overrun = overrun_q;
  assign o_break   = break_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard; covers the
// timeout when UART_RX_TIMEOUT_EN is defined.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int TMO   = 100;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_break;
  logic       pop;
  logic       clr;
  logic [7:0] data;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       overrun;
  logic       brk;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic       exp_overrun = 1'b0;
  logic [7:0] last_popped;

  uart_rx_fifo #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_wb_clk     (clk),
    .wb_rst       (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_rx_break   (rx_break),
    .i_pop        (pop),
    .i_clr_status (clr),
    .o_data       (data),
    .o_empty      (empty),
    .o_full       (full),
    .o_level      (level),
    .o_overrun    (overrun),
    .o_break      (brk),
    .o_timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    if (sb.size() < DEPTH) sb.push_back(b);
    else exp_overrun = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    check(tag, {24'b0, data}, {24'b0, sb[0]});
    last_popped = sb.pop_front();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic check_level(input string tag);
    check(tag, {27'b0, level}, sb.size());
  endtask

  initial begin
    int cyc;
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_break = 1'b0; pop = 1'b0; clr = 1'b0;
    #22 rst = 1'b0;
    tick();
    check("rst_level", {27'b0, level}, 0);
    check("rst_empty", {31'b0, empty}, 1);
    check("rst_full", {31'b0, full}, 0);
    check("rst_overrun", {31'b0, overrun}, 0);
    check("rst_break", {31'b0, brk}, 0);
    check("rst_timeout", {31'b0, timeout}, 0);

    // Three bytes in, three out.
    push_byte(8'h41); check_level("lvl_1");
    check("head_after_push", {24'b0, data}, 32'h41);
    push_byte(8'h42); check_level("lvl_2");
    push_byte(8'h43); check_level("lvl_3");
    pop_check("data_41"); check_level("lvl_2b");
    pop_check("data_42"); check_level("lvl_1b");
    pop_check("data_43"); check_level("lvl_0");
    check("empty_after_drain", {31'b0, empty}, 1);

    // Overflow by one.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("full_after_16", {31'b0, full}, 1);
    check("no_overrun_at_16", {31'b0, overrun}, 0);
    push_byte(8'h10);
    check("overrun_after_17", {31'b0, overrun}, {31'b0, exp_overrun});
    check_level("lvl_16_after_17");
    for (int i = 0; i < 16; i++) pop_check("drain_overflow");
    check("empty_after_overflow_drain", {31'b0, empty}, 1);
    clr = 1'b1; tick(); clr = 1'b0; exp_overrun = 1'b0;
    check("overrun_cleared", {31'b0, overrun}, 0);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
    check("head_before_simul", {24'b0, data}, 32'h80);
    last_popped = sb.pop_front();
    sb.push_back(8'h55);
    rx_data = 8'h55; rx_valid = 1'b1; pop = 1'b1;
    tick();
    rx_valid = 1'b0; pop = 1'b0;
    check("simul_full_level", {27'b0, level}, 16);
    check("simul_full_no_overrun", {31'b0, overrun}, 0);
    check("simul_full_still_full", {31'b0, full}, 1);
    for (int i = 0; i < 16; i++) pop_check("drain_simul");
    check("last_is_55", {24'b0, last_popped}, 32'h55);

    // Pop on empty is harmless; push+pop on empty keeps the push.
    pop = 1'b1; tick(); pop = 1'b0;
    check("pop_empty_level", {27'b0, level}, 0);
    check("pop_empty_overrun", {31'b0, overrun}, 0);
    sb.push_back(8'h3C);
    rx_data = 8'h3C; rx_valid = 1'b1; pop = 1'b1;
    tick();
    rx_valid = 1'b0; pop = 1'b0;
    check_level("simul_empty_level");
    pop_check("simul_empty_data");

    // Break set wins over clear; clear alone then clears.
    rx_break = 1'b1; clr = 1'b1; tick(); rx_break = 1'b0; clr = 1'b0;
    check("break_set_wins", {31'b0, brk}, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("break_cleared", {31'b0, brk}, 0);

    // Idle timeout.
    push_byte(8'hA5);
    cyc = 0;
    while (!timeout && cyc < 200) begin
      tick();
      cyc++;
    end
`ifdef UART_RX_TIMEOUT_EN
    check("timeout_latency", cyc, TMO);
    pop_check("timeout_data");
    check("timeout_cleared", {31'b0, timeout}, 0);
`else
    check("timeout_disabled", cyc, 200);
    pop_check("timeout_data");
    check("timeout_stays_0", {31'b0, timeout}, 0);
`endif
    check("empty_after_timeout", {31'b0, empty}, 1);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    check_level("pre_reset_level");
    #2 rst = 1'b1;
    #1;
    check("async_rst_level", {27'b0, level}, 0);
    check("async_rst_empty", {31'b0, empty}, 1);
    sb.delete();
    @(negedge clk) rst = 1'b0;
    tick();
    push_byte(8'h77);
    pop_check("post_reset_data");
    check("post_reset_empty", {31'b0, empty}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
